// File: rtl/fwd_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_unit
// Brief    : Operand-forwarding select and load-use stall unit for a
//            5-stage pipeline, with a saturating stall performance counter.
// Revision : 1.0 - initial release
// ============================================================================

module fwd_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [4:0]       id_dst,
    input  logic             id_wen,
    input  logic             id_is_load,
    input  logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] c_SEL_RF    = 2'd0;
    localparam logic [1:0] c_SEL_EXMEM = 2'd1;
    localparam logic [1:0] c_SEL_MEMWB = 2'd2;

    typedef struct packed {
        logic [4:0] dst;
        logic       wen;
        logic       is_load;
    } slot_t;

    localparam slot_t c_BUBBLE = '0;

    slot_t r_ex;
    slot_t r_mem;
    slot_t r_wb;

    // True when slot s writes a nonzero register equal to src; optionally
    // also requires the slot to be a load.
    function automatic logic slot_hit(input slot_t s, input logic [4:0] src,
                                      input logic need_load);
        return s.wen && (s.dst == src) && (src != 5'd0) &&
               (!need_load || s.is_load);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] src,
                                           input slot_t ex, input slot_t mem,
                                           input slot_t wb);
        if (!used)
            return c_SEL_RF;
        if (slot_hit(ex, src, 1'b0))
            return c_SEL_EXMEM;
        if (slot_hit(mem, src, 1'b0))
            return c_SEL_MEMWB;
        // A WB producer is covered by the register file's write-before-read.
        if (slot_hit(wb, src, 1'b0))
            return c_SEL_RF;
        return c_SEL_RF;
    endfunction

    logic  w_load_hit_a;
    logic  w_load_hit_b;
    logic  w_stall;
    logic  w_issue;
    slot_t w_id_slot;

    assign w_load_hit_a = id_rs_used && slot_hit(r_ex, id_rs, 1'b1);
    assign w_load_hit_b = id_rt_used && slot_hit(r_ex, id_rt, 1'b1);
    assign w_stall      = !rst && (w_load_hit_a || w_load_hit_b);
    assign w_issue      = !w_stall && !flush;
    assign w_id_slot    = '{dst: id_dst, wen: id_wen, is_load: id_is_load};

    assign stall = w_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex      <= c_BUBBLE;
            r_mem     <= c_BUBBLE;
            r_wb      <= c_BUBBLE;
            fwd_a     <= c_SEL_RF;
            fwd_b     <= c_SEL_RF;
            stall_cnt <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            if (w_issue) begin
                r_ex  <= w_id_slot;
                fwd_a <= fwd_sel(id_rs_used, id_rs, r_ex, r_mem, r_wb);
                fwd_b <= fwd_sel(id_rt_used, id_rt, r_ex, r_mem, r_wb);
            end else begin
                r_ex  <= c_BUBBLE;
                fwd_a <= c_SEL_RF;
                fwd_b <= c_SEL_RF;
            end
            if (w_stall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_unit
// Brief    : Self-checking bench for fwd_unit: directed hazard scenarios plus
//            randomized traffic checked against an in-bench pipeline model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_fwd_unit;

    localparam int CW = 2;
    localparam int OW = 5 + CW;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rs_used;
        logic       rt_used;
        logic [4:0] dst;
        logic       wen;
        logic       is_load;
    } instr_t;

    typedef struct packed {
        instr_t in;
        logic   fl;
        logic   r;
    } op_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs, id_rt, id_dst;
    logic          id_rs_used, id_rt_used, id_wen, id_is_load, flush;
    logic [1:0]    fwd_a, fwd_b;
    logic          stall;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    fwd_unit #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_dst(id_dst), .id_wen(id_wen), .id_is_load(id_is_load),
        .flush(flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .stall_cnt(stall_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: hist[0] is the instruction in EX, hist[1] in MEM, hist[2] in WB.
    instr_t     hist[$];
    logic       e_stall;
    logic [1:0] e_fa, e_fb;
    int         e_cnt;
    logic       obs_stall;
    logic [OW-1:0] obs, exp_v;

    function automatic instr_t alu(input int d, input int a, input int b);
        instr_t i;
        i = '{rs: 5'(a), rt: 5'(b), rs_used: 1'b1, rt_used: 1'b1,
              dst: 5'(d), wen: 1'b1, is_load: 1'b0};
        return i;
    endfunction

    function automatic instr_t ld(input int d, input int a);
        instr_t i;
        i = '{rs: 5'(a), rt: 5'd0, rs_used: 1'b1, rt_used: 1'b0,
              dst: 5'(d), wen: 1'b1, is_load: 1'b1};
        return i;
    endfunction

    function automatic op_t op(input instr_t in, input logic fl = 1'b0,
                               input logic r = 1'b0);
        op_t o;
        o = '{in: in, fl: fl, r: r};
        return o;
    endfunction

    function automatic logic produces(input instr_t s, input logic [4:0] r);
        return s.wen && (s.dst == r) && (r != 5'd0);
    endfunction

    // Distance to the nearest producer among the two youngest issued slots.
    function automatic logic [1:0] model_sel(input logic used, input logic [4:0] r);
        if (!used)
            return 2'd0;
        for (int d = 0; d < 2; d++)
            if (produces(hist[d], r))
                return 2'(d + 1);
        return 2'd0;
    endfunction

    task automatic cycle(input op_t o);
        @(negedge clk);
        id_rs      = o.in.rs;      id_rt      = o.in.rt;
        id_rs_used = o.in.rs_used; id_rt_used = o.in.rt_used;
        id_dst     = o.in.dst;     id_wen     = o.in.wen;
        id_is_load = o.in.is_load; flush      = o.fl;  rst = o.r;
        #1;
        obs_stall = stall;
        e_stall = !o.r && hist[0].is_load &&
                  ((o.in.rs_used && produces(hist[0], o.in.rs)) ||
                   (o.in.rt_used && produces(hist[0], o.in.rt)));
        if (o.r) begin
            hist = {};
            repeat (3) hist.push_back('0);
            e_fa = 2'd0; e_fb = 2'd0; e_cnt = 0;
        end else begin
            if (e_stall && e_cnt < (1 << CW) - 1)
                e_cnt++;
            if (!e_stall && !o.fl) begin
                e_fa = model_sel(o.in.rs_used, o.in.rs);
                e_fb = model_sel(o.in.rt_used, o.in.rt);
                hist.push_front(o.in);
            end else begin
                e_fa = 2'd0; e_fb = 2'd0;
                hist.push_front('0);
            end
            void'(hist.pop_back());
        end
        @(posedge clk);
        #1;
        obs   = {obs_stall, fwd_a, fwd_b, stall_cnt};
        exp_v = {e_stall, e_fa, e_fb, CW'(e_cnt)};
    endtask

    task automatic test_reset();
        instr_t junk;
        for (int i = 0; i < 3; i++) begin
            junk = alu($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
            cycle(op(junk, 1'b0, 1'b1));
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset step %0d: got %h want %h", i, obs, exp_v);
            end
        end
        n_checks++;
        if ({obs_stall, fwd_a, fwd_b, stall_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got %h want 0", {obs_stall, fwd_a, fwd_b, stall_cnt});
        end
    endtask

    task automatic test_ex_fwd();
        op_t p[$];
        p.push_back(op(alu(3, 1, 2)));
        p.push_back(op(alu(8, 3, 9)));
        for (int i = 0; i < p.size(); i++) begin
            cycle(p[i]);
            n_checks++;
            if (obs !== exp_v || obs_stall !== 1'b0) begin
                n_fail++;
                $display("FAIL ex_fwd step %0d: got %h want %h", i, obs, exp_v);
            end
        end
        n_checks++;
        if (fwd_a !== 2'd1 || fwd_b !== 2'd0) begin
            n_fail++;
            $display("FAIL ex_fwd_sel: got a=%0d b=%0d want a=1 b=0", fwd_a, fwd_b);
        end
    endtask

    task automatic test_mem_fwd();
        op_t p[$];
        logic [1:0] want[$];
        p.push_back(op(alu(3, 1, 2)));   want.push_back(2'd0);
        p.push_back(op(alu(10, 11, 12))); want.push_back(2'd0);
        p.push_back(op(alu(13, 14, 3))); want.push_back(2'd2);
        p.push_back(op(alu(3, 1, 2)));   want.push_back(2'd0);
        p.push_back(op(alu(10, 11, 12))); want.push_back(2'd0);
        p.push_back(op(alu(15, 1, 2)));  want.push_back(2'd0);
        p.push_back(op(alu(13, 14, 3))); want.push_back(2'd0);
        for (int i = 0; i < p.size(); i++) begin
            cycle(p[i]);
            n_checks++;
            if (obs !== exp_v || fwd_b !== want[i]) begin
                n_fail++;
                $display("FAIL mem_fwd step %0d: got %h fwd_b=%0d want %h fwd_b=%0d",
                         i, obs, fwd_b, exp_v, want[i]);
            end
        end
    endtask

    task automatic test_load_use();
        cycle(op(alu(0, 0, 0), 1'b0, 1'b1));
        cycle(op(ld(5, 1)));
        cycle(op(alu(6, 5, 7)));
        n_checks++;
        if (obs !== exp_v || obs_stall !== 1'b1 || stall_cnt !== 2'd1 || fwd_a !== 2'd0) begin
            n_fail++;
            $display("FAIL load_use_stall: got %h want %h", obs, exp_v);
        end
        cycle(op(alu(6, 5, 7)));
        n_checks++;
        if (obs !== exp_v || obs_stall !== 1'b0 || stall_cnt !== 2'd1 || fwd_a !== 2'd2) begin
            n_fail++;
            $display("FAIL load_use_release: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_nearest();
        op_t p[$];
        p.push_back(op(alu(4, 1, 2)));
        p.push_back(op(alu(4, 1, 2)));
        p.push_back(op(alu(9, 4, 4)));
        for (int i = 0; i < p.size(); i++) begin
            cycle(p[i]);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL nearest step %0d: got %h want %h", i, obs, exp_v);
            end
        end
        n_checks++;
        if (fwd_a !== 2'd1 || fwd_b !== 2'd1) begin
            n_fail++;
            $display("FAIL nearest_sel: got a=%0d b=%0d want a=1 b=1", fwd_a, fwd_b);
        end
    endtask

    task automatic test_r0();
        op_t p[$];
        p.push_back(op(alu(0, 1, 2)));
        p.push_back(op(ld(0, 1)));
        p.push_back(op(alu(9, 0, 0)));
        p.push_back(op(alu(9, 0, 0)));
        for (int i = 0; i < p.size(); i++) begin
            cycle(p[i]);
            n_checks++;
            if (obs !== exp_v || obs_stall !== 1'b0 || (i >= 2 && {fwd_a, fwd_b} !== 4'd0)) begin
                n_fail++;
                $display("FAIL r0 step %0d: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_saturate_flush();
        logic [CW-1:0] want_cnt[4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        cycle(op(alu(0, 0, 0), 1'b0, 1'b1));
        for (int k = 0; k < 4; k++) begin
            cycle(op(ld(5, 1)));
            cycle(op(alu(6, 5, 7)));
            cycle(op(alu(6, 5, 7)));
            n_checks++;
            if (obs !== exp_v || stall_cnt !== want_cnt[k]) begin
                n_fail++;
                $display("FAIL saturate pair %0d: got %h cnt=%0d want %h cnt=%0d",
                         k, obs, stall_cnt, exp_v, want_cnt[k]);
            end
        end
        cycle(op(alu(0, 0, 0), 1'b0, 1'b1));
        n_checks++;
        if (obs !== exp_v || stall_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL cnt_reset: got %h want %h", obs, exp_v);
        end
        cycle(op(ld(5, 1)));
        cycle(op(alu(6, 5, 7), 1'b1));
        n_checks++;
        if (obs !== exp_v || obs_stall !== 1'b1 || {fwd_a, fwd_b} !== 4'd0 || stall_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL flush_in_stall: got %h want %h", obs, exp_v);
        end
        cycle(op(alu(6, 5, 7)));
        n_checks++;
        if (obs !== exp_v || fwd_a !== 2'd2) begin
            n_fail++;
            $display("FAIL flush_after: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_reset_mid_stall();
        cycle(op(ld(5, 1)));
        cycle(op(alu(6, 5, 7), 1'b0, 1'b1));
        n_checks++;
        if (obs !== exp_v || obs_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_stall: got %h want %h", obs, exp_v);
        end
        cycle(op(alu(6, 5, 7)));
        n_checks++;
        if (obs !== exp_v || obs_stall !== 1'b0 || fwd_a !== 2'd0 || stall_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL after_reset_no_stall: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_random();
        instr_t cur;
        logic   hold = 1'b0;
        logic   fl, r;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                cur.rs      = 5'($urandom_range(0, 3));
                cur.rt      = 5'($urandom_range(0, 3));
                cur.rs_used = 1'($urandom_range(0, 1));
                cur.rt_used = 1'($urandom_range(0, 1));
                cur.dst     = 5'($urandom_range(0, 3));
                cur.wen     = ($urandom_range(0, 3) != 0);
                cur.is_load = 1'($urandom_range(0, 1));
            end
            fl = ($urandom_range(0, 7) == 0);
            r  = ($urandom_range(0, 49) == 0);
            cycle(op(cur, fl, r));
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL random step %0d: got %h want %h", i, obs, exp_v);
            end
            hold = obs_stall && !fl;
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        id_rs = '0; id_rt = '0; id_dst = '0;
        id_rs_used = 1'b0; id_rt_used = 1'b0; id_wen = 1'b0; id_is_load = 1'b0;
        e_fa = 2'd0; e_fb = 2'd0; e_cnt = 0; e_stall = 1'b0;
        repeat (3) hist.push_back('0);
        test_reset();
        test_ex_fwd();
        test_mem_fwd();
        test_load_use();
        test_nearest();
        test_r0();
        test_saturate_flush();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
